branch_seq: RTL and testbench

//  Control sequencer for conditional branch instructions (brzr/brnz/brpl/brmi).

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/sat_counter.sv | 28 ++
 rtl/branch_seq.sv | 137 +++++++++++++
 tb/tb_branch_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: branch sequencer states, branch opcode,
// C2 condition encodings and the registered strobe bundle.
package cpu_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned C2_W  = 2;

  localparam logic [OPC_W-1:0] OP_BR = 5'b10011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EVAL = 3'd1,
    LDY  = 3'd2,
    ADD  = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;

  typedef enum logic [C2_W-1:0] {
    C2_ZR = 2'b00,
    C2_NZ = 2'b01,
    C2_PL = 2'b10,
    C2_MI = 2'b11
  } c2_t;

  // Registered control outputs of the branch sequencer
  typedef struct packed {
    logic busy;
    logic done;
    logic bad_op;
    logic gra;
    logic r_out;
    logic con_in;
    logic pc_out;
    logic y_in;
    logic c_out;
    logic alu_add;
    logic z_in;
    logic z_lo_out;
    logic pc_in;
  } strobes_t;

  function automatic logic is_branch(input logic [31:0] ir);
    return ir[31:27] == OP_BR;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//  clk, reset_n : clock, async active-low reset (clears count)
//  inc          : count up by one this cycle
//  clr          : synchronous clear, dominates inc
//  count        : current value
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch control sequencer (brzr/brnz/brpl/brmi).
// Steps EVAL -> LDY -> ADD -> WB -> DONE, driving one group of datapath
// strobes per step, and keeps saturating total/taken branch counters.
//  clk, reset_n      : clock, async active-low reset
//  start, ir         : one-cycle request with the decoded instruction
//  stall             : datapath not ready, freezes the sequence
//  con_out           : CON FF result (1 = branch taken)
//  busy, done, bad_op: sequence status / pulses
//  gra .. pc_in      : datapath strobes, all registered Moore outputs
//  total_cnt, taken_cnt : saturating statistics
module branch_seq
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             stall,
  input  logic             con_out,
  output logic             busy,
  output logic             done,
  output logic             bad_op,
  output logic             gra,
  output logic             r_out,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             z_lo_out,
  output logic             pc_in,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t   state, next_state;
  strobes_t strb, next_strb;
  logic     br_req;
  logic     wb_exit;
  logic     unused_ir;

  assign br_req    = is_branch(ir);
  // Only the opcode matters here; the condition bits feed the CON FF directly.
  assign unused_ir = ^ir[26:0];

  // State and strobe registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      strb  <= '0;
    end else begin
      state <= next_state;
      strb  <= next_strb;
    end
  end

  // Next state and next-cycle strobes, decoded from the next state
  always_comb begin
    next_state = state;
    next_strb  = '0;

    case (state)
      IDLE: if (start && br_req) next_state = EVAL;
      // Leave EVAL only after con_in has been seen high with the datapath ready,
      // so the CON FF always gets a clean edge after a stall.
      EVAL: if (!stall && strb.con_in) next_state = LDY;
      LDY:  if (!stall) next_state = ADD;
      ADD:  if (!stall) next_state = WB;
      WB:   if (!stall) next_state = DONE;
      DONE: if (!stall) next_state = IDLE;
      default: next_state = IDLE;
    endcase

    next_strb.busy   = (next_state != IDLE);
    next_strb.bad_op = (state == IDLE) && start && !br_req;

    case (next_state)
      EVAL: begin
        next_strb.gra    = 1'b1;
        next_strb.r_out  = 1'b1;
        next_strb.con_in = !stall;
      end
      LDY: begin
        next_strb.pc_out = 1'b1;
        next_strb.y_in   = 1'b1;
      end
      ADD: begin
        next_strb.c_out   = 1'b1;
        next_strb.alu_add = 1'b1;
        next_strb.z_in    = 1'b1;
      end
      WB: begin
        next_strb.z_lo_out = 1'b1;
        next_strb.pc_in    = con_out;
      end
      DONE:    next_strb.done = 1'b1;
      default: next_strb = next_strb;
    endcase
  end

  assign busy     = strb.busy;
  assign done     = strb.done;
  assign bad_op   = strb.bad_op;
  assign gra      = strb.gra;
  assign r_out    = strb.r_out;
  assign con_in   = strb.con_in;
  assign pc_out   = strb.pc_out;
  assign y_in     = strb.y_in;
  assign c_out    = strb.c_out;
  assign alu_add  = strb.alu_add;
  assign z_in     = strb.z_in;
  assign z_lo_out = strb.z_lo_out;
  assign pc_in    = strb.pc_in;

  // Statistics update on the WB -> DONE edge
  assign wb_exit = (state == WB) && !stall;

  sat_counter #(.CNT_W(CNT_W)) u_total_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (wb_exit),
    .clr     (1'b0),
    .count   (total_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (wb_exit && con_out),
    .clr     (1'b0),
    .count   (taken_cnt)
  );

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: directed scenarios plus randomized
// branches/stalls against a trace-building reference model.
module tb_branch_seq;
  import cpu_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MAXV = (1 << CNT_W) - 1;

  // Bit positions of the observed strobe vector
  localparam int B_BUSY = 12, B_DONE = 11, B_BAD = 10, B_GRA = 9, B_ROUT = 8;
  localparam int B_CONIN = 7, B_PCOUT = 6, B_YIN = 5, B_COUT = 4, B_ADD = 3;
  localparam int B_ZIN = 2, B_ZLO = 1, B_PCIN = 0;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      ir = '0;
  logic             stall = 1'b0;
  logic             con_out = 1'b0;
  logic             busy, done, bad_op, gra, r_out, con_in, pc_out, y_in;
  logic             c_out, alu_add, z_in, z_lo_out, pc_in;
  logic [CNT_W-1:0] total_cnt, taken_cnt;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned m_total = 0;
  int unsigned m_taken = 0;

  always #5 clk = ~clk;

  branch_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ir(ir), .stall(stall),
    .con_out(con_out), .busy(busy), .done(done), .bad_op(bad_op), .gra(gra),
    .r_out(r_out), .con_in(con_in), .pc_out(pc_out), .y_in(y_in), .c_out(c_out),
    .alu_add(alu_add), .z_in(z_in), .z_lo_out(z_lo_out), .pc_in(pc_in),
    .total_cnt(total_cnt), .taken_cnt(taken_cnt)
  );

  a_one_bus: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0({r_out, pc_out, c_out, z_lo_out}))
    else $error("FAIL bus_exclusive r_out=%b pc_out=%b c_out=%b z_lo_out=%b",
                r_out, pc_out, c_out, z_lo_out);

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [12:0] obs();
    return {busy, done, bad_op, gra, r_out, con_in, pc_out, y_in,
            c_out, alu_add, z_in, z_lo_out, pc_in};
  endfunction

  // Expected outputs for a step: 0 idle, 1 EVAL .. 5 DONE, 6 bad-op pulse
  function automatic logic [12:0] exp_vec(input int ph, input bit con_on, input bit taken);
    logic [12:0] v;
    v = '0;
    if (ph >= 1 && ph <= 5) v[B_BUSY] = 1'b1;
    case (ph)
      1: begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_CONIN] = con_on; end
      2: begin v[B_PCOUT] = 1'b1; v[B_YIN] = 1'b1; end
      3: begin v[B_COUT] = 1'b1; v[B_ADD] = 1'b1; v[B_ZIN] = 1'b1; end
      4: begin v[B_ZLO] = 1'b1; v[B_PCIN] = taken; end
      5: v[B_DONE] = 1'b1;
      6: v[B_BAD] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // CON FF behaviour: branch condition from C2 and the Ra register value
  function automatic bit con_model(input logic [1:0] c2, input logic [31:0] ra);
    case (c2)
      2'b00:   return ra == 32'd0;
      2'b01:   return ra != 32'd0;
      2'b10:   return !ra[31];
      default: return ra[31];
    endcase
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v < CNT_MAXV) ? v + 1 : v;
  endfunction

  // One branch; k[p] = stall cycles held in step p (k[1] counts from the start edge)
  task automatic run_branch(input string tag, input logic [1:0] c2, input logic [31:0] ra,
                            input int k[6], input bit noise);
    logic [12:0] exp_q[$];
    bit          st_q[$];
    int          ph_q[$];
    bit          taken;
    int unsigned old_total, old_taken, new_total, new_taken, et, ek;
    taken = con_model(c2, ra);
    old_total = m_total;
    old_taken = m_taken;
    new_total = sat_inc(m_total);
    new_taken = taken ? sat_inc(m_taken) : m_taken;

    // edge i produces cycle i+1: pairs of (stall at edge, expected next cycle)
    for (int j = 0; j < k[1]; j++) begin
      st_q.push_back(1'b1); exp_q.push_back(exp_vec(1, 1'b0, taken)); ph_q.push_back(1);
    end
    st_q.push_back(1'b0); exp_q.push_back(exp_vec(1, 1'b1, taken)); ph_q.push_back(1);
    for (int p = 2; p <= 5; p++) begin
      st_q.push_back(1'b0); exp_q.push_back(exp_vec(p, 1'b0, taken)); ph_q.push_back(p);
      for (int j = 0; j < k[p]; j++) begin
        st_q.push_back(1'b1); exp_q.push_back(exp_vec(p, 1'b0, taken)); ph_q.push_back(p);
      end
    end
    st_q.push_back(1'b0); exp_q.push_back(exp_vec(0, 1'b0, taken)); ph_q.push_back(0);

    @(negedge clk);
    ir = $urandom;
    ir[31:27] = OP_BR;
    ir[20:19] = c2;
    start = 1'b1;
    con_out = taken;
    stall = st_q[0];
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check({tag, "_strobes"}, 32'(obs()), 32'(exp_q[i]));
      et = (ph_q[i] == 5 || ph_q[i] == 0) ? new_total : old_total;
      ek = (ph_q[i] == 5 || ph_q[i] == 0) ? new_taken : old_taken;
      check({tag, "_total"}, 32'(total_cnt), et);
      check({tag, "_taken"}, 32'(taken_cnt), ek);
      if (i + 1 < exp_q.size()) begin
        stall = st_q[i + 1];
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        ir = $urandom;
      end else begin
        stall = 1'b0;
        start = 1'b0;
      end
    end
    m_total = new_total;
    m_taken = new_taken;
  endtask

  task automatic run_bad(input string tag, input logic [4:0] op, input bit st);
    @(negedge clk);
    ir = $urandom;
    ir[31:27] = op;
    start = 1'b1;
    stall = st;
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    check({tag, "_pulse"}, 32'(obs()), 32'(exp_vec(6, 1'b0, 1'b0)));
    check({tag, "_total"}, 32'(total_cnt), m_total);
    @(negedge clk);
    check({tag, "_after"}, 32'(obs()), 32'(exp_vec(0, 1'b0, 1'b0)));
    check({tag, "_taken"}, 32'(taken_cnt), m_taken);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    m_total = 0;
    m_taken = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int          k[6];
    logic [31:0] ra;
    logic [4:0]  op;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_strobes", 32'(obs()), 32'(exp_vec(0, 1'b0, 1'b0)));
    check("reset_total", 32'(total_cnt), 32'd0);
    check("reset_taken", 32'(taken_cnt), 32'd0);
    reset_n = 1'b1;

    // Taken brzr, then not-taken brnz, no stalls
    k = '{0, 0, 0, 0, 0, 0};
    run_branch("brzr_taken", 2'b00, 32'd0, k, 1'b0);
    run_branch("brnz_not", 2'b01, 32'd0, k, 1'b0);

    // Non-branch opcode
    run_bad("bad_op", 5'b00011, 1'b0);

    // Three stall cycles entering EVAL (stall also high in IDLE at start)
    k = '{0, 3, 0, 0, 0, 0};
    run_branch("eval_stall", 2'b00, 32'd0, k, 1'b0);

    // Reset in the middle of ADD: everything drops at once, PC never loaded
    @(negedge clk);
    ir = '0;
    ir[31:27] = OP_BR;
    start = 1'b1;
    con_out = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_add", 32'(obs()), 32'(exp_vec(3, 1'b0, 1'b1)));
    #1 reset_n = 1'b0;
    #1;
    check("midreset_strobes", 32'(obs()), 32'(exp_vec(0, 1'b0, 1'b0)));
    check("midreset_total", 32'(total_cnt), 32'd0);
    check("midreset_taken", 32'(taken_cnt), 32'd0);
    m_total = 0;
    m_taken = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(obs()), 32'(exp_vec(0, 1'b0, 1'b0)));
    k = '{0, 0, 0, 0, 0, 0};
    run_branch("after_reset", 2'b00, 32'd0, k, 1'b0);

    // Randomized branches, stalls, ignored starts and bad opcodes
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 5'($urandom);
        if (op == OP_BR) op = 5'b00000;
        run_bad("rnd_bad", op, 1'($urandom_range(0, 1)));
      end else begin
        for (int p = 1; p <= 5; p++)
          k[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        ra = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        run_branch("rnd_br", 2'($urandom_range(0, 3)), ra, k, 1'b1);
      end
    end

    // Saturation: 17 taken branches with start pulses during each busy period
    do_reset();
    k = '{0, 0, 0, 0, 0, 0};
    for (int t = 0; t < 17; t++) begin
      run_branch("sat", 2'b11, 32'h8000_0000, k, 1'b1);
    end
    check("sat_taken_final", 32'(taken_cnt), 32'(CNT_MAXV));
    check("sat_total_final", 32'(total_cnt), 32'(CNT_MAXV));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
